// File: rtl/orion_types.sv
// rtl/orion_types.sv - shared widths and enums for the orion memory path
package orion_types;

    localparam int ADDRW = 32;
    localparam int XLEN  = 32;
    localparam int MASKW = XLEN / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_t;

    // Winner when both sides request in the same IDLE cycle.
    function automatic grant_t contention_winner(input logic fair, input grant_t last);
        if (fair && last == GNT_D) begin
            return GNT_I;
        end
        return GNT_D;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - bundle of the fetch, load/store and unified memory port signals
interface mem_arbiter_if;
    import orion_types::*;

    logic [ADDRW-1:0] imem_addr_i;
    logic             imem_valid_i;
    logic             imem_flush_i;
    logic [XLEN-1:0]  imem_rdata_o;
    logic             imem_resp_o;

    logic [ADDRW-1:0] dmem_addr_i;
    logic [XLEN-1:0]  dmem_wdata_i;
    logic [MASKW-1:0] dmem_mask_i;
    logic             dmem_we_i;
    logic             dmem_valid_i;
    logic [XLEN-1:0]  dmem_rdata_o;
    logic             dmem_resp_o;

    logic [ADDRW-1:0] mem_addr_o;
    logic [XLEN-1:0]  mem_wdata_o;
    logic [MASKW-1:0] mem_mask_o;
    logic             mem_we_o;
    logic             mem_valid_o;
    logic [XLEN-1:0]  mem_rdata_i;
    logic             mem_resp_i;

    modport slave (
        input  imem_addr_i, imem_valid_i, imem_flush_i,
        input  dmem_addr_i, dmem_wdata_i, dmem_mask_i, dmem_we_i, dmem_valid_i,
        input  mem_rdata_i, mem_resp_i,
        output imem_rdata_o, imem_resp_o, dmem_rdata_o, dmem_resp_o,
        output mem_addr_o, mem_wdata_o, mem_mask_o, mem_we_o, mem_valid_o
    );

    modport master (
        output imem_addr_i, imem_valid_i, imem_flush_i,
        output dmem_addr_i, dmem_wdata_i, dmem_mask_i, dmem_we_i, dmem_valid_i,
        output mem_rdata_i, mem_resp_i,
        input  imem_rdata_o, imem_resp_o, dmem_rdata_o, dmem_resp_o,
        input  mem_addr_o, mem_wdata_o, mem_mask_o, mem_we_o, mem_valid_o
    );

endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates core fetch and load/store requests onto one memory port
module mem_arbiter
    import orion_types::*;
#(
    parameter bit FAIR = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,

    input  logic [ADDRW-1:0] imem_addr_i,
    input  logic             imem_valid_i,
    input  logic             imem_flush_i,
    output logic [XLEN-1:0]  imem_rdata_o,
    output logic             imem_resp_o,

    input  logic [ADDRW-1:0] dmem_addr_i,
    input  logic [XLEN-1:0]  dmem_wdata_i,
    input  logic [MASKW-1:0] dmem_mask_i,
    input  logic             dmem_we_i,
    input  logic             dmem_valid_i,
    output logic [XLEN-1:0]  dmem_rdata_o,
    output logic             dmem_resp_o,

    output logic [ADDRW-1:0] mem_addr_o,
    output logic [XLEN-1:0]  mem_wdata_o,
    output logic [MASKW-1:0] mem_mask_o,
    output logic             mem_we_o,
    output logic             mem_valid_o,
    input  logic [XLEN-1:0]  mem_rdata_i,
    input  logic             mem_resp_i
);

    arb_state_t       state_q, state_d;
    grant_t           last_q, last_d;
    grant_t           gnt;
    logic             drop_q, drop_d;
    logic [ADDRW-1:0] addr_q, addr_d;
    logic [XLEN-1:0]  wdata_q, wdata_d;
    logic [MASKW-1:0] mask_q, mask_d;
    logic             we_q, we_d;

    logic busy;
    logic busy_i;
    logic busy_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            last_q  <= GNT_I;
            drop_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            drop_q  <= drop_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
            we_q    <= we_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        drop_d  = drop_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mask_d  = mask_q;
        we_d    = we_q;
        gnt     = GNT_I;

        case (state_q)
            IDLE: begin
                if (imem_valid_i || dmem_valid_i) begin
                    if (imem_valid_i && dmem_valid_i) begin
                        gnt = contention_winner(FAIR, last_q);
                    end else begin
                        gnt = imem_valid_i ? GNT_I : GNT_D;
                    end
                    last_d = gnt;
                    if (gnt == GNT_I) begin
                        // Fetches are always full-word reads.
                        state_d = BUSY_I;
                        addr_d  = imem_addr_i;
                        wdata_d = '0;
                        mask_d  = '1;
                        we_d    = 1'b0;
                        drop_d  = imem_flush_i;
                    end else begin
                        state_d = BUSY_D;
                        addr_d  = dmem_addr_i;
                        wdata_d = dmem_wdata_i;
                        mask_d  = dmem_mask_i;
                        we_d    = dmem_we_i;
                        drop_d  = 1'b0;
                    end
                end
            end
            BUSY_I: begin
                if (imem_flush_i) begin
                    drop_d = 1'b1;
                end
                if (mem_resp_i) begin
                    state_d = IDLE;
                    drop_d  = 1'b0;
                end
            end
            BUSY_D: begin
                if (mem_resp_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                drop_d  = 1'b0;
            end
        endcase
    end

    // Outputs are forced low while reset is held so an abandoned access vanishes at once.
    assign busy   = !rst_i && (state_q != IDLE);
    assign busy_i = !rst_i && (state_q == BUSY_I);
    assign busy_d = !rst_i && (state_q == BUSY_D);

    assign mem_valid_o = busy;
    assign mem_addr_o  = busy ? addr_q  : '0;
    assign mem_wdata_o = busy ? wdata_q : '0;
    assign mem_mask_o  = busy ? mask_q  : '0;
    assign mem_we_o    = busy && we_q;

    // A flush arriving in the completion cycle itself also suppresses the response.
    assign imem_resp_o  = busy_i && mem_resp_i && !drop_q && !imem_flush_i;
    assign imem_rdata_o = imem_resp_o ? mem_rdata_i : '0;
    assign dmem_resp_o  = busy_d && mem_resp_i;
    assign dmem_rdata_o = dmem_resp_o ? mem_rdata_i : '0;

endmodule
